// File: rtl/gfp8_nv_pack.sv
// gfp8_nv_pack
// Collects 128 scalar GFP results (32b signed mantissa m, 8b signed exponent e,
// value m * 2^e) and re-quantises them into one packed GFP8 Native Vector:
// 4 groups x 32 int8 mantissas plus one biased exponent byte per group.
//
// Ports
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_clear              synchronous abort: drop partial/held NV, clear flags
//   i_result_valid/o_result_ready, i_result_mantissa, i_result_exponent
//                        input element stream
//   o_nv_valid/i_nv_ready, o_exp_packed, o_man_packed[0:3]
//                        packed NV output
//   o_underflow          sticky: some group exponent was clamped to 0
//   o_dbg_state          current FSM state (COLLECT/EXPO/NORM/OUT)
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. o_result_ready and o_nv_valid are registered. o_nv_valid stays
// at 1 with stable data until the transfer edge.
//
// Sequencing: COLLECT stores elements and tracks each group's maximum of
// e + bitlen(|m|). EXPO (one cycle) registers the per-group scale and exponent
// byte. NORM then quantises LANES elements per cycle. OUT holds the NV.
module gfp8_nv_pack #(
    parameter int LANES    = 4,
    parameter int EXP_BIAS = 15
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_clear,
    input  logic         i_result_valid,
    output logic         o_result_ready,
    input  logic [31:0]  i_result_mantissa,
    input  logic [7:0]   i_result_exponent,
    output logic         o_nv_valid,
    input  logic         i_nv_ready,
    output logic [31:0]  o_exp_packed,
    output logic [255:0] o_man_packed [0:3],
    output logic         o_underflow,
    output logic [1:0]   o_dbg_state
);

    localparam int                NCHUNK     = 128 / LANES;
    localparam logic [6:0]        LAST_CHUNK = 7'(NCHUNK - 1);
    localparam logic signed [9:0] T_TO_E     = 10'(EXP_BIAS - 7);
    localparam logic signed [9:0] T_MIN      = 10'(7 - EXP_BIAS);
    localparam logic signed [9:0] S_CLAMP    = 10'(-EXP_BIAS);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_EXPO    = 2'd1,
        S_NORM    = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ready;
    logic              r_valid;
    logic [6:0]        r_cnt;        // element index in COLLECT, chunk index in NORM
    logic [31:0]       r_man  [0:127];
    logic [7:0]        r_exp  [0:127];
    logic signed [9:0] r_tmax [0:3];
    logic [3:0]        r_nz;         // group holds at least one nonzero mantissa
    logic signed [9:0] r_s    [0:3];
    logic [7:0]        r_eb   [0:3];
    logic              r_uf;
    logic [255:0]      r_out  [0:3];

    logic              w_accept;
    logic [1:0]        w_grp;
    logic [31:0]       w_abs;
    logic [5:0]        w_nb;
    logic signed [9:0] w_t;
    logic signed [9:0] w_s    [0:3];
    logic [7:0]        w_eb   [0:3];
    logic [3:0]        w_uf;
    logic [6:0]        w_idx  [0:LANES-1];
    logic signed [10:0] w_sh  [0:LANES-1];
    logic [7:0]        w_q    [0:LANES-1];

    // Quantise one element by an arithmetic shift of sh. Left shifts are
    // bounded to 7 because the group scale is never below e + bitlen - 7.
    // Right shifts round half-up on a 41b sign-extended value, then the
    // result saturates symmetrically to [-127, 127].
    function automatic logic [7:0] f_quant(input logic [31:0] m,
                                           input logic signed [10:0] sh,
                                           input logic nz);
        logic signed [40:0] v;
        logic [5:0]         amt;
        v   = {{9{m[31]}}, m};
        amt = 6'd0;
        if (!nz) begin
            v = '0;
        end else if (sh <= 11'sd0) begin
            amt = 6'(-sh);
            v   = v <<< amt;
        end else if (sh > 11'sd40) begin
            v = '0;
        end else begin
            amt = sh[5:0];
            v   = (v + (41'sd1 <<< (amt - 6'd1))) >>> amt;
        end
        if (v > 41'sd127) begin
            return 8'h7F;
        end else if (v < -41'sd127) begin
            return 8'h81;
        end
        return v[7:0];
    endfunction

    assign w_accept = (r_state == S_COLLECT) && r_ready && i_result_valid && !i_clear;
    assign w_grp    = r_cnt[6:5];

    // Bit length of |m|; -2^31 maps to 32 since its magnitude is 2^31.
    always_comb begin
        w_abs = i_result_mantissa[31] ? (~i_result_mantissa + 32'd1) : i_result_mantissa;
        w_nb  = 6'd0;
        for (int i = 0; i < 32; i++) begin
            if (w_abs[i]) begin
                w_nb = 6'(i + 1);
            end
        end
        w_t = $signed({{2{i_result_exponent[7]}}, i_result_exponent}) + $signed({4'd0, w_nb});
    end

    // Group scale s = T - 7 and exponent byte E = T - 7 + bias, with the
    // negative-E clamp. All-zero groups emit E = 0 and are not underflow.
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            w_s[g]  = r_tmax[g] - 10'sd7;
            w_eb[g] = 8'(r_tmax[g] + T_TO_E);
            w_uf[g] = 1'b0;
            if (!r_nz[g]) begin
                w_eb[g] = 8'd0;
            end else if (r_tmax[g] < T_MIN) begin
                w_eb[g] = 8'd0;
                w_s[g]  = S_CLAMP;
                w_uf[g] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_idx[j] = 7'(int'(r_cnt) * LANES + j);
            w_sh[j]  = $signed({r_s[w_idx[j][6:5]][9], r_s[w_idx[j][6:5]]})
                     - $signed({{3{r_exp[w_idx[j]][7]}}, r_exp[w_idx[j]]});
            w_q[j]   = f_quant(r_man[w_idx[j]], w_sh[j], r_nz[w_idx[j][6:5]]);
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_clear) begin
            w_next = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (w_accept && r_cnt == 7'd127) w_next = S_EXPO;
                S_EXPO:    w_next = S_NORM;
                S_NORM:    if (r_cnt == LAST_CHUNK) w_next = S_OUT;
                S_OUT:     if (i_nv_ready) w_next = S_COLLECT;
                default:   w_next = S_COLLECT;
            endcase
        end
    end

    // Ready/valid are decoded from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_COLLECT;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_COLLECT);
            r_valid <= (w_next == S_OUT);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
            r_nz  <= '0;
            r_uf  <= 1'b0;
            for (int i = 0; i < 128; i++) begin
                r_man[i] <= '0;
                r_exp[i] <= '0;
            end
            for (int g = 0; g < 4; g++) begin
                r_tmax[g] <= '0;
                r_s[g]    <= '0;
                r_eb[g]   <= '0;
                r_out[g]  <= '0;
            end
        end else if (i_clear) begin
            r_cnt <= '0;
            r_nz  <= '0;
            r_uf  <= 1'b0;
            for (int g = 0; g < 4; g++) begin
                r_tmax[g] <= '0;
            end
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        r_man[r_cnt] <= i_result_mantissa;
                        r_exp[r_cnt] <= i_result_exponent;
                        r_cnt        <= r_cnt + 7'd1;
                        // Lane 0 seeds the group maximum so an all-negative
                        // group is not biased by a stale cleared value.
                        if (r_cnt[4:0] == 5'd0) begin
                            r_tmax[w_grp] <= w_t;
                            r_nz[w_grp]   <= (w_nb != 6'd0);
                        end else begin
                            if (w_t > r_tmax[w_grp]) r_tmax[w_grp] <= w_t;
                            if (w_nb != 6'd0)        r_nz[w_grp]   <= 1'b1;
                        end
                    end
                end
                S_EXPO: begin
                    for (int g = 0; g < 4; g++) begin
                        r_s[g]  <= w_s[g];
                        r_eb[g] <= w_eb[g];
                    end
                    if (|w_uf) r_uf <= 1'b1;
                    r_cnt <= '0;
                end
                S_NORM: begin
                    for (int j = 0; j < LANES; j++) begin
                        r_out[w_idx[j][6:5]][{w_idx[j][4:0], 3'b000} +: 8] <= w_q[j];
                    end
                    r_cnt <= (r_cnt == LAST_CHUNK) ? 7'd0 : r_cnt + 7'd1;
                end
                S_OUT: begin
                    if (i_nv_ready) begin
                        r_cnt <= '0;
                        r_nz  <= '0;
                        for (int g = 0; g < 4; g++) begin
                            r_tmax[g] <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result_ready = r_ready;
    assign o_nv_valid     = r_valid;
    assign o_exp_packed   = {r_eb[3], r_eb[2], r_eb[1], r_eb[0]};
    assign o_underflow    = r_uf;
    assign o_dbg_state    = r_state;

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            o_man_packed[g] = r_out[g];
        end
    end

endmodule

// File: tb/tb_gfp8_nv_pack.sv
// tb_gfp8_nv_pack
// Self-checking bench for gfp8_nv_pack: directed vector table, random NVs
// checked against a value-level reference model, and hand-written sequences
// for backpressure, clear and asynchronous reset.
module tb_gfp8_nv_pack;

    localparam int LANES    = 4;
    localparam int EXP_BIAS = 15;
    localparam int LAT      = 128 / LANES + 1;

    logic         i_clk             = 1'b0;
    logic         i_reset_n         = 1'b0;
    logic         i_clear           = 1'b0;
    logic         i_result_valid    = 1'b0;
    logic [31:0]  i_result_mantissa = '0;
    logic [7:0]   i_result_exponent = '0;
    logic         i_nv_ready        = 1'b0;
    logic         o_result_ready;
    logic         o_nv_valid;
    logic [31:0]  o_exp_packed;
    logic [255:0] o_man_packed [0:3];
    logic         o_underflow;
    logic [1:0]   o_dbg_state;

    gfp8_nv_pack #(.LANES(LANES), .EXP_BIAS(EXP_BIAS)) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_clear           (i_clear),
        .i_result_valid    (i_result_valid),
        .o_result_ready    (o_result_ready),
        .i_result_mantissa (i_result_mantissa),
        .i_result_exponent (i_result_exponent),
        .o_nv_valid        (o_nv_valid),
        .i_nv_ready        (i_nv_ready),
        .o_exp_packed      (o_exp_packed),
        .o_man_packed      (o_man_packed),
        .o_underflow       (o_underflow),
        .o_dbg_state       (o_dbg_state)
    );

    // clock
    always #5 i_clk = ~i_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int           n_total   = 0;
    int           n_bad     = 0;
    int           extra_acc = 0;
    bit           uf_model  = 1'b0;
    int           el_m [128];
    int           el_e [128];
    logic [255:0] exp_q [$];
    logic [31:0]  cur_exp;
    logic [255:0] cur_man [4];

    typedef struct {
        int         pat;
        logic [31:0] exp_word;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       uf;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbits(input longint a);
        int n = 0;
        while (a != 0) begin
            a = a >> 1;
            n++;
        end
        return n;
    endfunction

    // Value m * 2^-sh rounded half-up (floor(x + 1/2)), saturated to +-127.
    function automatic int quant(input longint m, input int sh);
        longint r, num, d;
        if (sh <= 0) begin
            r = m * (longint'(1) << (-sh));
        end else if (sh > 40) begin
            r = 0;
        end else begin
            num = m + (longint'(1) << (sh - 1));
            d   = longint'(1) << sh;
            r   = num / d;
            if ((num % d != 0) && (num < 0)) r = r - 1;
        end
        if (r > 127)  r = 127;
        if (r < -127) r = -127;
        return int'(r);
    endfunction

    task automatic build_model();
        logic [255:0] gv;
        logic [31:0]  ew;
        int t, s, eb, v, k;
        bit any;
        longint am;
        ew = '0;
        exp_q.push_back('0);
        for (int g = 0; g < 4; g++) begin
            any = 1'b0;
            t   = -100000;
            for (int l = 0; l < 32; l++) begin
                k  = g * 32 + l;
                am = longint'(el_m[k]);
                if (am < 0) am = -am;
                if (am != 0) any = 1'b1;
                v = el_e[k] + nbits(am);
                if (v > t) t = v;
            end
            gv = '0;
            eb = 0;
            if (any) begin
                s  = t - 7;
                eb = s + EXP_BIAS;
                if (eb < 0) begin
                    eb       = 0;
                    s        = -EXP_BIAS;
                    uf_model = 1'b1;
                end
                for (int l = 0; l < 32; l++) begin
                    k = g * 32 + l;
                    gv[8*l +: 8] = 8'(quant(longint'(el_m[k]), s - el_e[k]));
                end
            end
            ew[8*g +: 8] = 8'(eb);
            exp_q.push_back(gv);
        end
        exp_q[exp_q.size() - 5] = {224'd0, ew};
    endtask

    // ---------------- stimulus ----------------
    task automatic fill_pattern(input int pat);
        for (int k = 0; k < 128; k++) begin
            el_m[k] = 0;
            el_e[k] = 0;
        end
        case (pat)
            0: for (int k = 0; k < 32; k++) el_m[k] = 1;
            1: begin
                el_m[0] = 383;
                el_m[1] = -383;
                el_m[2] = 1;
            end
            2: el_m[0] = 255;
            default: for (int k = 0; k < 128; k++) begin
                el_m[k] = 1;
                el_e[k] = -100;
            end
        endcase
    endtask

    task automatic fill_random(input bit wide_e);
        int          w, zg;
        logic [31:0] r;
        for (int k = 0; k < 128; k++) begin
            w = int'($urandom_range(32, 0));
            r = $urandom;
            if (w == 0) r = '0;
            else if (w < 32) r = r >> (32 - w);
            if ($urandom_range(1, 0) == 1) r = -r;
            if ($urandom_range(50, 0) == 0) r = 32'h8000_0000;
            el_m[k] = int'(r);
            if (wide_e) el_e[k] = int'($signed(8'($urandom)));
            else        el_e[k] = int'($urandom_range(40, 0)) - 20;
        end
        if ($urandom_range(3, 0) == 0) begin
            zg = int'($urandom_range(3, 0));
            for (int l = 0; l < 32; l++) el_m[zg*32 + l] = 0;
        end
    endtask

    task automatic send_elems(input int first, input int n, input int gap_pct, input bit keep_valid);
        int idx, guard;
        bit acc;
        idx   = first;
        guard = 0;
        while (idx < first + n && guard < 4000) begin
            i_result_valid    = (int'($urandom_range(99, 0)) >= gap_pct);
            i_result_mantissa = el_m[idx];
            i_result_exponent = 8'(el_e[idx]);
            acc = i_result_valid && o_result_ready;
            @(posedge i_clk); #1;
            if (acc) idx++;
            guard++;
        end
        if (!keep_valid) i_result_valid = 1'b0;
        chk("send_count", 256'(idx - first), 256'(n));
    endtask

    task automatic wait_nv(output int lat);
        lat = 0;
        while (!o_nv_valid && lat < 200) begin
            if (i_result_valid && o_result_ready) extra_acc++;
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic check_nv();
        logic [255:0] e;
        if (exp_q.size() < 5) begin
            n_total++;
            n_bad++;
            $display("FAIL nv_queue: got=%0d entries expected=5", exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        cur_exp = e[31:0];
        chk("nv_exp", {224'd0, o_exp_packed}, e);
        for (int g = 0; g < 4; g++) begin
            e = exp_q.pop_front();
            cur_man[g] = e;
            chk($sformatf("nv_man_g%0d", g), o_man_packed[g], e);
        end
        chk("nv_underflow", o_underflow, uf_model);
        chk("nv_ready_low", o_result_ready, 1'b0);
    endtask

    task automatic nv_handshake(input int hold);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", o_nv_valid, 1'b1);
            chk("hold_ready", o_result_ready, 1'b0);
            chk("hold_exp", {224'd0, o_exp_packed}, {224'd0, cur_exp});
            for (int g = 0; g < 4; g++) chk("hold_man", o_man_packed[g], cur_man[g]);
            if (i_result_valid && o_result_ready) extra_acc++;
            @(posedge i_clk); #1;
        end
        i_nv_ready     = 1'b1;
        i_result_valid = 1'b0;
        @(posedge i_clk); #1;
        i_nv_ready = 1'b0;
        chk("post_hs_valid", o_nv_valid, 1'b0);
        chk("post_hs_ready", o_result_ready, 1'b1);
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_clear  = 1'b0;
        uf_model = 1'b0;
        exp_q.delete();
    endtask

    task automatic full_nv(input int gap_pct, input int hold);
        int lat;
        build_model();
        send_elems(0, 128, gap_pct, 1'b0);
        wait_nv(lat);
        chk("nv_latency", 256'(lat), 256'(LAT));
        check_nv();
        nv_handshake(hold);
    endtask

    // ---------------- main ----------------
    initial begin
        int lat, saw;

        tbl[0] = '{0, 32'h0000_0009, 8'h40, 8'h40, 8'h40, 1'b0};
        tbl[1] = '{1, 32'h0000_0011, 8'h60, 8'hA0, 8'h00, 1'b0};
        tbl[2] = '{2, 32'h0000_0010, 8'h7F, 8'h00, 8'h00, 1'b0};
        tbl[3] = '{3, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 1'b1};

        // reset
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ready", o_result_ready, 1'b0);
        chk("rst_valid", o_nv_valid, 1'b0);
        chk("rst_exp", {224'd0, o_exp_packed}, '0);
        chk("rst_uf", o_underflow, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        chk("rel_ready_before_clk", o_result_ready, 1'b0);
        @(posedge i_clk); #1;
        chk("rel_ready_after_clk", o_result_ready, 1'b1);

        // directed table
        for (int i = 0; i < 4; i++) begin
            fill_pattern(tbl[i].pat);
            build_model();
            send_elems(0, 128, 0, 1'b0);
            wait_nv(lat);
            chk("tbl_latency", 256'(lat), 256'(LAT));
            chk("tbl_exp", {224'd0, o_exp_packed}, {224'd0, tbl[i].exp_word});
            chk("tbl_b0", o_man_packed[0][7:0], tbl[i].b0);
            chk("tbl_b1", o_man_packed[0][15:8], tbl[i].b1);
            chk("tbl_b2", o_man_packed[0][23:16], tbl[i].b2);
            chk("tbl_uf", o_underflow, tbl[i].uf);
            check_nv();
            nv_handshake(0);
        end
        chk("uf_sticky_after_hs", o_underflow, 1'b1);
        pulse_clear();
        chk("uf_cleared", o_underflow, 1'b0);

        // random NVs against the reference model
        for (int r = 0; r < 6; r++) begin
            fill_random(r[0]);
            full_nv(20, int'($urandom_range(3, 0)));
        end

        // backpressure with continuous input valid
        fill_random(1'b0);
        build_model();
        extra_acc = 0;
        send_elems(0, 128, 0, 1'b1);
        wait_nv(lat);
        chk("bp_latency", 256'(lat), 256'(LAT));
        check_nv();
        nv_handshake(10);
        chk("bp_extra_accepts", 256'(extra_acc), '0);

        // clear after 50 accepts, then a fresh NV
        fill_random(1'b0);
        send_elems(0, 50, 10, 1'b0);
        pulse_clear();
        chk("clr_ready", o_result_ready, 1'b1);
        chk("clr_valid", o_nv_valid, 1'b0);
        fill_random(1'b0);
        full_nv(10, 1);

        // clear during OUT, coincident with a handshake, drops the NV
        fill_random(1'b0);
        send_elems(0, 128, 0, 1'b0);
        wait_nv(lat);
        chk("clrout_valid_before", o_nv_valid, 1'b1);
        i_nv_ready = 1'b1;
        pulse_clear();
        i_nv_ready = 1'b0;
        chk("clrout_valid", o_nv_valid, 1'b0);
        chk("clrout_ready", o_result_ready, 1'b1);
        saw = 0;
        repeat (40) begin
            if (o_nv_valid) saw = 1;
            @(posedge i_clk); #1;
        end
        chk("clrout_no_valid", 256'(saw), '0);

        // async reset mid-NORM; group 3 underflows so the flag is set first
        fill_random(1'b0);
        for (int l = 0; l < 32; l++) begin
            el_m[96 + l] = 1;
            el_e[96 + l] = -100;
        end
        send_elems(0, 128, 0, 1'b0);
        repeat (5) begin
            @(posedge i_clk); #1;
        end
        chk("pre_rst_uf", o_underflow, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_ready", o_result_ready, 1'b0);
        chk("arst_valid", o_nv_valid, 1'b0);
        chk("arst_exp", {224'd0, o_exp_packed}, '0);
        chk("arst_uf", o_underflow, 1'b0);
        for (int g = 0; g < 4; g++) chk("arst_man", o_man_packed[g], '0);
        uf_model = 1'b0;
        exp_q.delete();
        @(posedge i_clk);
        #3;
        i_reset_n = 1'b1;
        chk("arst_rel_ready", o_result_ready, 1'b0);
        @(posedge i_clk); #1;
        chk("arst_first_clk_ready", o_result_ready, 1'b1);

        // 127 accepts must not produce an NV; the 128th does
        fill_random(1'b1);
        build_model();
        send_elems(0, 127, 15, 1'b0);
        saw = 0;
        repeat (40) begin
            if (o_nv_valid) saw = 1;
            @(posedge i_clk); #1;
        end
        chk("no_early_valid", 256'(saw), '0);
        send_elems(127, 1, 0, 1'b0);
        wait_nv(lat);
        chk("post_rst_latency", 256'(lat), 256'(LAT));
        check_nv();
        nv_handshake(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
